// File: rtl/sp_ram_fifo.sv
// sp_ram_fifo: FIFO built on one single-port RAM with a registered read
// port, followed by an output register with a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_valid/wr_ready   write handshake, wr_data carries the word
//   rd_valid/rd_ready   output handshake, rd_data carries the word
//   count               words held (RAM + read in flight + output register)
//   full, empty         count == DEPTH, count == 0
//
// Build option: define SP_FIFO_BYPASS_EN to let a write into an otherwise
// empty FIFO load the output register directly, skipping the RAM.

module sp_ram_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_q;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] ram_addr;
    logic              in_flight;
    logic [ADDR_W:0]   ram_words;

    logic rd_issue;
    logic wr_fire;
    logic rd_fire;
    logic bypass;
    logic ram_wr;

    // Words still sitting in the RAM, not yet read out.
    assign ram_words = count
                     - (ADDR_W + 1)'(in_flight)
                     - (ADDR_W + 1)'(rd_valid);

    // A read needs the RAM port, nothing already in the read pipe, and
    // a slot in the output register by the time the data lands.
    assign rd_issue = (ram_words != '0)
                   && !in_flight
                   && (!rd_valid || rd_ready);

    assign full  = (count == DEPTH_L);
    assign empty = (count == '0);

    // Reads own the single RAM port; a write only gets it when idle.
    assign wr_ready = rst_n && !full && !rd_issue;

    assign wr_fire = wr_valid && wr_ready;
    assign rd_fire = rd_valid && rd_ready;

`ifdef SP_FIFO_BYPASS_EN
    localparam logic [ADDR_W:0] ONE_L = (ADDR_W + 1)'(1);

    // With nothing else queued, the written word can go straight to the
    // output register without breaking order.
    assign bypass = wr_fire
                 && ((count == '0) || ((count == ONE_L) && rd_fire));
`else
    assign bypass = 1'b0;
`endif

    assign ram_wr   = wr_fire && !bypass;
    assign ram_addr = rd_issue ? rd_ptr : wr_ptr;

    // RAM contents are never reset; at most one access per cycle.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr] <= wr_data;
        end
        if (rd_issue) begin
            ram_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            in_flight <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            count     <= '0;
        end else begin
            if (ram_wr) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end

            in_flight <= rd_issue;

            // An in-flight read implies the output register is free now,
            // and bypass only fires when no read can be in flight.
            if (in_flight) begin
                rd_valid <= 1'b1;
                rd_data  <= ram_q;
            end else if (bypass) begin
                rd_valid <= 1'b1;
                rd_data  <= wr_data;
            end else if (rd_fire) begin
                rd_valid <= 1'b0;
            end

            if (wr_fire && !rd_fire) begin
                count <= count + (ADDR_W + 1)'(1);
            end else if (rd_fire && !wr_fire) begin
                count <= count - (ADDR_W + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_sp_ram_fifo.sv
// tb_sp_ram_fifo: randomized bench for sp_ram_fifo (ADDR_W = 4) checked
// against a queue model of the FIFO contents.

module tb_sp_ram_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = 8'h00;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic [4:0] count;
    logic       full;
    logic       empty;

    int checks = 0;
    int failures = 0;

    logic [7:0] q[$];

`ifdef SP_FIFO_BYPASS_EN
    localparam int FIRST_EDGE = 0;
`else
    localparam int FIRST_EDGE = 2;
`endif

    sp_ram_fifo #(
        .DATA_W(8),
        .ADDR_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_data(wr_data),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_data(rd_data),
        .count(count),
        .full(full),
        .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Called at a falling edge: drive, sample handshakes, run one edge,
    // return at the next falling edge.
    task automatic cycle(input logic wv, input logic [7:0] wd,
                         input logic rr, output logic wf,
                         output logic rf, output logic [7:0] rd);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        #1;
        wf = wv && wr_ready;
        rf = rd_valid && rr;
        rd = rd_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_valid = 1'b1;
        #1;
        checks++;
        if (count !== 5'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", count);
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags empty=%b full=%b exp 1/0", empty, full);
        end
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_wr_ready got=%b exp=0", wr_ready);
        end
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_out rd_valid=%b rd_data=%h exp 0/00",
                     rd_valid, rd_data);
        end
        wr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_wr_ready got=%b exp=1", wr_ready);
        end
        q.delete();
    endtask

    task automatic test_first_word();
        logic wf, rf;
        logic [7:0] rd;
        logic [7:0] got;
        int edge_seen;
        got = 8'h00;
        edge_seen = -1;
        cycle(1'b1, 8'hA5, 1'b1, wf, rf, rd);
        checks++;
        if (wf !== 1'b1) begin
            failures++;
            $display("FAIL first_accept got=%b exp=1", wf);
        end
        checks++;
        if (count !== 5'd1) begin
            failures++;
            $display("FAIL first_count got=%0d exp=1", count);
        end
        for (int k = 1; k <= 6 && edge_seen < 0; k++) begin
            cycle(1'b0, 8'h00, 1'b1, wf, rf, rd);
            if (rf) begin
                edge_seen = k - 1;
                got = rd;
            end
        end
        checks++;
        if (edge_seen != FIRST_EDGE) begin
            failures++;
            $display("FAIL first_latency got=%0d exp=%0d",
                     edge_seen, FIRST_EDGE);
        end
        checks++;
        if (got !== 8'hA5) begin
            failures++;
            $display("FAIL first_data got=%h exp=a5", got);
        end
        checks++;
        if (count !== 5'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL first_drain count=%0d empty=%b exp 0/1",
                     count, empty);
        end
    endtask

    task automatic test_fill();
        logic wf, rf;
        logic [7:0] rd;
        int accepted;
        int got;
        accepted = 0;
        for (int i = 0; i < 16; i++) begin
            wf = 1'b0;
            for (int t = 0; t < 10 && !wf; t++) begin
                cycle(1'b1, 8'(i), 1'b0, wf, rf, rd);
            end
            if (wf) begin
                q.push_back(8'(i));
                accepted++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b0, wf, rf, rd);
        end
        checks++;
        if (accepted != 16) begin
            failures++;
            $display("FAIL fill_accepted got=%0d exp=16", accepted);
        end
        checks++;
        if (count !== 5'd16 || full !== 1'b1) begin
            failures++;
            $display("FAIL fill_full count=%0d full=%b exp 16/1", count, full);
        end
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_wr_ready got=%b exp=0", wr_ready);
        end
        cycle(1'b1, 8'hEE, 1'b0, wf, rf, rd);
        checks++;
        if (wf !== 1'b0 || count !== 5'd16) begin
            failures++;
            $display("FAIL fill_17th accepted=%b count=%0d exp 0/16",
                     wf, count);
        end
        got = 0;
        for (int t = 0; t < 100 && q.size() > 0; t++) begin
            cycle(1'b0, 8'h00, 1'b1, wf, rf, rd);
            if (rf) begin
                checks++;
                if (rd !== q[0]) begin
                    failures++;
                    $display("FAIL fill_order got=%h exp=%h", rd, q[0]);
                end
                void'(q.pop_front());
                got++;
            end
        end
        checks++;
        if (got != 16 || empty !== 1'b1 || count !== 5'd0) begin
            failures++;
            $display("FAIL fill_drain words=%0d empty=%b count=%0d exp 16/1/0",
                     got, empty, count);
        end
        q.delete();
    endtask

    task automatic test_wrap();
        logic wf, rf;
        logic [7:0] rd;
        logic rr;
        int sent;
        int recv;
        sent = 0;
        recv = 0;
        for (int c = 0; c < 3000 && recv < 40; c++) begin
            rr = 1'($urandom_range(0, 1));
            cycle(sent < 40, 8'(sent), rr, wf, rf, rd);
            if (wf) begin
                q.push_back(8'(sent));
                sent++;
            end
            if (rf) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL wrap_spurious got=%h exp=none", rd);
                end else begin
                    if (rd !== q[0]) begin
                        failures++;
                        $display("FAIL wrap_order got=%h exp=%h", rd, q[0]);
                    end
                    void'(q.pop_front());
                end
                recv++;
            end
            checks++;
            if (count !== 5'(q.size())) begin
                failures++;
                $display("FAIL wrap_count got=%0d exp=%0d", count, q.size());
            end
            if (empty) begin
                checks++;
                if (rd_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL wrap_empty_valid got=%b exp=0", rd_valid);
                end
            end
        end
        checks++;
        if (sent != 40 || recv != 40 || q.size() != 0) begin
            failures++;
            $display("FAIL wrap_total sent=%0d recv=%0d left=%0d exp 40/40/0",
                     sent, recv, q.size());
        end
        q.delete();
    endtask

    task automatic test_stream();
        logic wf, rf;
        logic [7:0] rd;
        logic [7:0] d;
        logic prev_wf;
        int loaded;
        loaded = 0;
        while (loaded < 8) begin
            d = 8'($urandom);
            wf = 1'b0;
            for (int t = 0; t < 10 && !wf; t++) begin
                cycle(1'b1, d, 1'b0, wf, rf, rd);
            end
            if (wf) q.push_back(d);
            loaded++;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b0, wf, rf, rd);
        end
        checks++;
        if (count !== 5'd8) begin
            failures++;
            $display("FAIL stream_preload got=%0d exp=8", count);
        end
        prev_wf = 1'b1;
        for (int c = 0; c < 40; c++) begin
            d = 8'($urandom);
            cycle(1'b1, d, 1'b1, wf, rf, rd);
            if (wf) q.push_back(d);
            if (rf) begin
                checks++;
                if (q.size() == 0 || rd !== q[0]) begin
                    failures++;
                    $display("FAIL stream_order got=%h", rd);
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            checks++;
            if (count > 5'd8) begin
                failures++;
                $display("FAIL stream_count got=%0d exp<=8", count);
            end
            checks++;
            if (wf === prev_wf) begin
                failures++;
                $display("FAIL stream_alternate cycle=%0d wr=%b prev=%b",
                         c, wf, prev_wf);
            end
            checks++;
            if (rf !== !wf) begin
                failures++;
                $display("FAIL stream_read cycle=%0d rd=%b wr=%b", c, rf, wf);
            end
            prev_wf = wf;
        end
        for (int t = 0; t < 100 && q.size() > 0; t++) begin
            cycle(1'b0, 8'h00, 1'b1, wf, rf, rd);
            if (rf) begin
                checks++;
                if (rd !== q[0]) begin
                    failures++;
                    $display("FAIL stream_drain got=%h exp=%h", rd, q[0]);
                end
                void'(q.pop_front());
            end
        end
        checks++;
        if (q.size() != 0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL stream_empty left=%0d empty=%b exp 0/1",
                     q.size(), empty);
        end
        q.delete();
    endtask

    task automatic test_reset_mid();
        logic wf, rf;
        logic [7:0] rd;
        int loaded;
        int stale;
        logic [7:0] got;
        loaded = 0;
        while (loaded < 6) begin
            wf = 1'b0;
            for (int t = 0; t < 10 && !wf; t++) begin
                cycle(1'b1, 8'(8'h50 + loaded), 1'b0, wf, rf, rd);
            end
            loaded++;
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h00, 1'b0, wf, rf, rd);
        end
        cycle(1'b0, 8'h00, 1'b1, wf, rf, rd);
        checks++;
        if (rf !== 1'b1 || rd !== 8'h50) begin
            failures++;
            $display("FAIL midrst_pre rd=%b data=%h exp 1/50", rf, rd);
        end
        checks++;
        if (count !== 5'd5 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL midrst_inflight count=%0d rd_valid=%b exp 5/0",
                     count, rd_valid);
        end
        rd_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 5'd0 || rd_valid !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL midrst_clear count=%0d rd_valid=%b empty=%b exp 0/0/1",
                     count, rd_valid, empty);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 8'h00, 1'b1, wf, rf, rd);
            if (rf || rd_valid) stale++;
        end
        checks++;
        if (stale != 0 || count !== 5'd0) begin
            failures++;
            $display("FAIL midrst_stale words=%0d count=%0d exp 0/0",
                     stale, count);
        end
        cycle(1'b1, 8'h3C, 1'b1, wf, rf, rd);
        got = 8'h00;
        rf = 1'b0;
        for (int t = 0; t < 8 && !rf; t++) begin
            cycle(1'b0, 8'h00, 1'b1, wf, rf, rd);
            if (rf) got = rd;
        end
        checks++;
        if (got !== 8'h3C) begin
            failures++;
            $display("FAIL midrst_after got=%h exp=3c", got);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_first_word();
        test_fill();
        test_wrap();
        test_stream();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
